// File: rtl/decode_stage_if.sv
// Port bundle for decode_stage: fetch word/PC, EX flush, writeback port, load-use stall,
// early redirect and the registered ID/EX bundle.
// Handshake: there is no valid/ready pair. Fetch presents a word every cycle; keep=1 means
// the IF/ID slot did not take it and fetch must hold; flush overrides keep.
interface decode_stage_if;
  logic [31:0] Instraction_pype;
  logic [31:0] PC_pype0;
  logic [31:0] PCp4_pype0;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        keep;
  logic        branch_PC_early_contral;
  logic [31:0] branch_PC_early;
  logic        valid_pype1;
  logic [31:0] PC_pype1;
  logic [31:0] PCp4_pype1;
  logic [31:0] rs1_data_pype1;
  logic [31:0] rs2_data_pype1;
  logic [31:0] imm_pype1;
  logic [4:0]  rs1_pype1;
  logic [4:0]  rs2_pype1;
  logic [4:0]  rd_pype1;
  logic [6:0]  opcode_pype1;
  logic [2:0]  funct3_pype1;
  logic        funct7b5_pype1;
  logic        mem_read_pype1;
  logic        mem_write_pype1;
  logic        reg_write_pype1;
  logic        early_taken_pype1;

  modport master (
    output Instraction_pype, PC_pype0, PCp4_pype0, flush, wb_we, wb_rd, wb_data,
    input  keep, branch_PC_early_contral, branch_PC_early, valid_pype1, PC_pype1,
           PCp4_pype1, rs1_data_pype1, rs2_data_pype1, imm_pype1, rs1_pype1, rs2_pype1,
           rd_pype1, opcode_pype1, funct3_pype1, funct7b5_pype1, mem_read_pype1,
           mem_write_pype1, reg_write_pype1, early_taken_pype1
  );

  modport slave (
    input  Instraction_pype, PC_pype0, PCp4_pype0, flush, wb_we, wb_rd, wb_data,
    output keep, branch_PC_early_contral, branch_PC_early, valid_pype1, PC_pype1,
           PCp4_pype1, rs1_data_pype1, rs2_data_pype1, imm_pype1, rs1_pype1, rs2_pype1,
           rd_pype1, opcode_pype1, funct3_pype1, funct7b5_pype1, mem_read_pype1,
           mem_write_pype1, reg_write_pype1, early_taken_pype1
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, 31x32 register file, immediates, load-use stall and
// optional early JAL/BEQ/BNE resolution (enabled by defining DECODE_EARLY_BRANCH_EN).
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0001_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0009
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave dif
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0] ifid_instr, ifid_pc, ifid_pcp4;
  logic        ifid_valid;
  logic [31:0] rf [31:1];

  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_early_taken, ex_f7b5;
  logic [31:0] ex_pc, ex_pcp4, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  f_rs1, f_rs2, f_rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = ifid_instr[6:0];
  assign funct3 = ifid_instr[14:12];
  assign f_rs1  = ifid_instr[19:15];
  assign f_rs2  = ifid_instr[24:20];
  assign f_rd   = ifid_instr[11:7];
  assign imm_i  = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
  assign imm_s  = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
  assign imm_b  = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7], ifid_instr[30:25],
                   ifid_instr[11:8], 1'b0};
  assign imm_u  = {ifid_instr[31:12], 12'h000};
  assign imm_j  = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12], ifid_instr[20],
                   ifid_instr[30:21], 1'b0};

  logic        legal, slot_valid, uses_rs1, uses_rs2, dec_rw, dec_mr, dec_mw;
  logic [31:0] dec_imm;

  always_comb begin
    legal    = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    dec_rw   = 1'b0;
    dec_mr   = 1'b0;
    dec_mw   = 1'b0;
    dec_imm  = 32'h0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin legal = 1'b1; dec_rw = 1'b1; dec_imm = imm_u; end
      OP_JAL:    begin legal = 1'b1; dec_rw = 1'b1; dec_imm = imm_j; end
      OP_JALR:   begin legal = 1'b1; dec_rw = 1'b1; uses_rs1 = 1'b1; dec_imm = imm_i; end
      OP_BRANCH: begin legal = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; dec_imm = imm_b; end
      OP_LOAD:   begin legal = 1'b1; dec_rw = 1'b1; dec_mr = 1'b1; uses_rs1 = 1'b1; dec_imm = imm_i; end
      OP_STORE:  begin legal = 1'b1; dec_mw = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; dec_imm = imm_s; end
      OP_IMM:    begin legal = 1'b1; dec_rw = 1'b1; uses_rs1 = 1'b1; dec_imm = imm_i; end
      OP_OP:     begin legal = 1'b1; dec_rw = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_FENCE, OP_SYSTEM: begin legal = 1'b1; dec_imm = imm_i; end
      default: ;
    endcase
    slot_valid = ifid_valid && (ifid_instr != NOP_WORD) && legal;
    // An invalid slot reads nothing and writes nothing, so it can never stall or redirect.
    if (!slot_valid) begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      dec_rw   = 1'b0;
      dec_mr   = 1'b0;
      dec_mw   = 1'b0;
      dec_imm  = 32'h0;
    end
  end

  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [31:0] rs1_val, rs2_val;

  assign rs1_idx = uses_rs1 ? f_rs1 : 5'd0;
  assign rs2_idx = uses_rs2 ? f_rs2 : 5'd0;
  assign rd_idx  = dec_rw   ? f_rd  : 5'd0;

  always_comb begin
    rs1_val = 32'h0;
    rs2_val = 32'h0;
    if (rs1_idx != 5'd0)
      rs1_val = (dif.wb_we && dif.wb_rd == rs1_idx) ? dif.wb_data : rf[rs1_idx];
    if (rs2_idx != 5'd0)
      rs2_val = (dif.wb_we && dif.wb_rd == rs2_idx) ? dif.wb_data : rf[rs2_idx];
  end

  logic load_use, keep;
  assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    ((uses_rs1 && f_rs1 == ex_rd) || (uses_rs2 && f_rs2 == ex_rd));
  assign keep = load_use && !dif.flush;

  logic        redirect;
  logic [31:0] target;
`ifdef DECODE_EARLY_BRANCH_EN
  logic is_jal, is_beq_bne, dep, taken;
  always_comb begin
    is_jal     = (opcode == OP_JAL);
    is_beq_bne = (opcode == OP_BRANCH) && (funct3[2:1] == 2'b00);
    dep        = ex_valid && ex_reg_write && (ex_rd != 5'd0) &&
                 ((ex_rd == f_rs1) || (ex_rd == f_rs2));
    // funct3[0] selects BNE, which inverts the equality result.
    taken      = is_jal || (is_beq_bne && !dep && ((rs1_val == rs2_val) != funct3[0]));
    redirect   = slot_valid && !keep && !dif.flush && taken;
    target     = redirect ? (ifid_pc + (is_jal ? imm_j : imm_b)) : 32'h0;
  end
`else
  assign redirect = 1'b0;
  assign target   = 32'h0;
`endif

  always_ff @(posedge clk) begin
    if (dif.wb_we && dif.wb_rd != 5'd0)
      rf[dif.wb_rd] <= dif.wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_instr <= NOP_WORD;
      ifid_valid <= 1'b0;
      ifid_pc    <= RESET_PC;
      ifid_pcp4  <= RESET_PC + 32'd4;
    end else if (dif.flush || redirect) begin
      ifid_instr <= NOP_WORD;
      ifid_valid <= 1'b0;
      ifid_pc    <= dif.PC_pype0;
      ifid_pcp4  <= dif.PCp4_pype0;
    end else if (!keep) begin
      ifid_instr <= dif.Instraction_pype;
      ifid_valid <= 1'b1;
      ifid_pc    <= dif.PC_pype0;
      ifid_pcp4  <= dif.PCp4_pype0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid       <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_early_taken <= 1'b0;
      ex_f7b5        <= 1'b0;
      ex_pc          <= RESET_PC;
      ex_pcp4        <= RESET_PC + 32'd4;
      ex_rs1_data    <= 32'h0;
      ex_rs2_data    <= 32'h0;
      ex_imm         <= 32'h0;
      ex_rs1         <= 5'd0;
      ex_rs2         <= 5'd0;
      ex_rd          <= 5'd0;
      ex_opcode      <= 7'd0;
      ex_funct3      <= 3'd0;
    end else begin
      ex_pc       <= ifid_pc;
      ex_pcp4     <= ifid_pcp4;
      ex_rs1_data <= rs1_val;
      ex_rs2_data <= rs2_val;
      ex_imm      <= dec_imm;
      if (dif.flush || keep) begin
        ex_valid       <= 1'b0;
        ex_mem_read    <= 1'b0;
        ex_mem_write   <= 1'b0;
        ex_reg_write   <= 1'b0;
        ex_early_taken <= 1'b0;
        ex_f7b5        <= 1'b0;
        ex_rs1         <= 5'd0;
        ex_rs2         <= 5'd0;
        ex_rd          <= 5'd0;
        ex_opcode      <= 7'd0;
        ex_funct3      <= 3'd0;
      end else begin
        ex_valid       <= slot_valid;
        ex_mem_read    <= dec_mr;
        ex_mem_write   <= dec_mw;
        ex_reg_write   <= dec_rw;
        ex_early_taken <= redirect;
        ex_f7b5        <= slot_valid & ifid_instr[30];
        ex_rs1         <= rs1_idx;
        ex_rs2         <= rs2_idx;
        ex_rd          <= rd_idx;
        ex_opcode      <= slot_valid ? opcode : 7'd0;
        ex_funct3      <= slot_valid ? funct3 : 3'd0;
      end
    end
  end

  assign dif.keep                    = keep;
  assign dif.branch_PC_early_contral = redirect;
  assign dif.branch_PC_early         = target;
  assign dif.valid_pype1             = ex_valid;
  assign dif.PC_pype1                = ex_pc;
  assign dif.PCp4_pype1              = ex_pcp4;
  assign dif.rs1_data_pype1          = ex_rs1_data;
  assign dif.rs2_data_pype1          = ex_rs2_data;
  assign dif.imm_pype1               = ex_imm;
  assign dif.rs1_pype1               = ex_rs1;
  assign dif.rs2_pype1               = ex_rs2;
  assign dif.rd_pype1                = ex_rd;
  assign dif.opcode_pype1            = ex_opcode;
  assign dif.funct3_pype1            = ex_funct3;
  assign dif.funct7b5_pype1          = ex_f7b5;
  assign dif.mem_read_pype1          = ex_mem_read;
  assign dif.mem_write_pype1         = ex_mem_write;
  assign dif.reg_write_pype1         = ex_reg_write;
  assign dif.early_taken_pype1       = ex_early_taken;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an instruction-level reference model.
module tb_decode_stage;
  localparam logic [31:0] RESET_PC = 32'h0001_0000;
  localparam logic [31:0] NOP      = 32'h0000_0009;

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BRANCH = 7'h63;
  localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, OPIMM = 7'h13, OPR = 7'h33;
  localparam logic [6:0] FENCE = 7'h0F, SYSTEM = 7'h73;

  localparam logic [31:0] ADDI6  = 32'h0012_8313; // addi x6,x5,1
  localparam logic [31:0] ADDI10 = 32'h0024_8513; // addi x10,x9,2
  localparam logic [31:0] LW7    = 32'h0000_A383; // lw x7,0(x1)
  localparam logic [31:0] ADD8   = 32'h0023_8433; // add x8,x7,x2
  localparam logic [31:0] JAL20  = 32'h0200_00EF; // jal x1,+0x20
  localparam logic [31:0] ADDI11 = 32'h0050_0593; // addi x11,x0,5
  localparam logic [31:0] BEQ34  = 32'h0041_8863; // beq x3,x4,+16
  localparam logic [31:0] ADDI3  = 32'h0001_8193; // addi x3,x3,0

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, pcp4, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        mr, mw, rw, et;
  } ex_t;
  localparam int EXW = $bits(ex_t);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if dif();
  decode_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP)) dut (.clk(clk), .rst(rst), .dif(dif.slave));

  int errors = 0;
  int checks = 0;
  logic [EXW-1:0] exp_q[$];
  bit cmp_on = 1'b0;

  // reference state: IF/ID slot, ID/EX bundle, architectural registers
  logic [31:0] m_rf [32];
  logic [31:0] m_w, m_pc, m_pcp4;
  logic        m_v;
  ex_t         m_ex;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_op(input logic [6:0] op);
    return op inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OPR, FENCE, SYSTEM};
  endfunction
  function automatic bit src1_used(input logic [6:0] op);
    return op inside {JALR, BRANCH, LOAD, STORE, OPIMM, OPR};
  endfunction
  function automatic bit src2_used(input logic [6:0] op);
    return op inside {BRANCH, STORE, OPR};
  endfunction
  function automatic bit writes_rd(input logic [6:0] op);
    return op inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OPR};
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] w);
    case (w[6:0])
      LUI, AUIPC: return {w[31:12], 12'h0};
      JAL:        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      BRANCH:     return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      STORE:      return {{20{w[31]}}, w[31:25], w[11:7]};
      OPR:        return 32'h0;
      default:    return {{20{w[31]}}, w[31:20]};
    endcase
  endfunction

  function automatic bit slot_ok();
    return m_v && (m_w != NOP) && legal_op(m_w[6:0]);
  endfunction

  function automatic logic [31:0] reg_val(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (dif.wb_we && dif.wb_rd == r) return dif.wb_data;
    return m_rf[r];
  endfunction

  function automatic bit exp_keep();
    logic [6:0] op;
    op = m_w[6:0];
    if (!slot_ok() || dif.flush) return 1'b0;
    if (!(m_ex.valid && m_ex.mr && m_ex.rd != 5'd0)) return 1'b0;
    return (src1_used(op) && m_w[19:15] == m_ex.rd) || (src2_used(op) && m_w[24:20] == m_ex.rd);
  endfunction

  function automatic void exp_redirect(output bit t, output logic [31:0] tgt);
    t = 1'b0;
    tgt = 32'h0;
`ifdef DECODE_EARLY_BRANCH_EN
    if (slot_ok() && !exp_keep() && !dif.flush) begin
      if (m_w[6:0] == JAL) begin
        t = 1'b1;
        tgt = m_pc + imm_of(m_w);
      end else if (m_w[6:0] == BRANCH && m_w[14:13] == 2'b00) begin
        if (!(m_ex.valid && m_ex.rw && m_ex.rd != 5'd0 &&
              (m_ex.rd == m_w[19:15] || m_ex.rd == m_w[24:20]))) begin
          t = (reg_val(m_w[19:15]) == reg_val(m_w[24:20])) ^ m_w[12];
          if (t) tgt = m_pc + imm_of(m_w);
        end
      end
    end
`endif
  endfunction

  function automatic ex_t decode_m(input bit et);
    ex_t e;
    logic [6:0] op;
    e = '0;
    op = m_w[6:0];
    e.pc = m_pc;
    e.pcp4 = m_pcp4;
    if (!slot_ok()) return e;
    e.valid = 1'b1;
    e.op = op;
    e.f3 = m_w[14:12];
    e.f7 = m_w[30];
    e.rs1 = src1_used(op) ? m_w[19:15] : 5'd0;
    e.rs2 = src2_used(op) ? m_w[24:20] : 5'd0;
    e.rd = writes_rd(op) ? m_w[11:7] : 5'd0;
    e.rs1d = reg_val(e.rs1);
    e.rs2d = reg_val(e.rs2);
    e.imm = imm_of(m_w);
    e.mr = (op == LOAD);
    e.mw = (op == STORE);
    e.rw = writes_rd(op);
    e.et = et;
    return e;
  endfunction

  // reference model advances one instruction slot per clock
  always @(posedge clk) begin
    bit k, rt;
    logic [31:0] tgt;
    ex_t nx;
    if (rst) begin
      m_w = NOP; m_v = 1'b0; m_pc = RESET_PC; m_pcp4 = RESET_PC + 32'd4;
      m_ex = '0; m_ex.pc = RESET_PC; m_ex.pcp4 = RESET_PC + 32'd4;
    end else begin
      k = exp_keep();
      exp_redirect(rt, tgt);
      nx = decode_m(rt);
      if (dif.flush || k) begin
        nx.valid = 1'b0; nx.mr = 1'b0; nx.mw = 1'b0; nx.rw = 1'b0; nx.et = 1'b0;
        nx.rd = 5'd0; nx.rs1 = 5'd0; nx.rs2 = 5'd0;
      end
      if (dif.flush || rt) begin
        m_w = NOP; m_v = 1'b0; m_pc = dif.PC_pype0; m_pcp4 = dif.PCp4_pype0;
      end else if (!k) begin
        m_w = dif.Instraction_pype; m_v = 1'b1; m_pc = dif.PC_pype0; m_pcp4 = dif.PCp4_pype0;
      end
      m_ex = nx;
    end
    if (dif.wb_we && dif.wb_rd != 5'd0) m_rf[dif.wb_rd] = dif.wb_data;
    exp_q.push_back(m_ex);
    cmp_on = 1'b1;
  end

  task automatic compare_cycle();
    ex_t e;
    bit rt;
    logic [31:0] tgt;
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("valid_pype1", dif.valid_pype1, e.valid);
    chk("mem_read_pype1", dif.mem_read_pype1, e.mr);
    chk("mem_write_pype1", dif.mem_write_pype1, e.mw);
    chk("reg_write_pype1", dif.reg_write_pype1, e.rw);
    chk("early_taken_pype1", dif.early_taken_pype1, e.et);
    chk("rd_pype1", dif.rd_pype1, e.rd);
    if (e.valid) begin
      chk("PC_pype1", dif.PC_pype1, e.pc);
      chk("PCp4_pype1", dif.PCp4_pype1, e.pcp4);
      chk("rs1_pype1", dif.rs1_pype1, e.rs1);
      chk("rs2_pype1", dif.rs2_pype1, e.rs2);
      chk("rs1_data_pype1", dif.rs1_data_pype1, e.rs1d);
      chk("rs2_data_pype1", dif.rs2_data_pype1, e.rs2d);
      chk("imm_pype1", dif.imm_pype1, e.imm);
      chk("opcode_pype1", dif.opcode_pype1, e.op);
      chk("funct3_pype1", dif.funct3_pype1, e.f3);
      chk("funct7b5_pype1", dif.funct7b5_pype1, e.f7);
    end
    chk("keep", dif.keep, exp_keep());
    exp_redirect(rt, tgt);
    chk("branch_PC_early_contral", dif.branch_PC_early_contral, rt);
    if (rt) chk("branch_PC_early", dif.branch_PC_early, tgt);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (cmp_on) compare_cycle();
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input bit fl = 1'b0,
                       input bit we = 1'b0, input logic [4:0] r = 5'd0,
                       input logic [31:0] d = 32'h0, input bit rs = 1'b0);
    @(negedge clk);
    rst = rs;
    dif.Instraction_pype = ins;
    dif.PC_pype0 = pc;
    dif.PCp4_pype0 = pc + 32'd4;
    dif.flush = fl;
    dif.wb_we = we;
    dif.wb_rd = r;
    dif.wb_data = d;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  a, b, d;
    logic [11:0] im;
    logic [19:0] j;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 7));
    im = 12'($urandom);
    j = 20'($urandom);
    case ($urandom_range(0, 11))
      0:  return {im, a, 3'b000, d, OPIMM};
      1:  return {im, a, 3'b010, d, LOAD};
      2:  return {1'b0, 1'($urandom_range(0, 1)), 5'b0, b, a, 3'b000, d, OPR};
      3:  return {im[11:5], b, a, 3'b010, im[4:0], STORE};
      4:  return {im[11:5], b, a, 3'b000, im[4:0], BRANCH};
      5:  return {im[11:5], b, a, 3'b001, im[4:0], BRANCH};
      6:  return {j, d, JAL};
      7:  return {j, d, LUI};
      8:  return NOP;
      9:  return $urandom;
      10: return {im[11:5], b, a, 3'b100, im[4:0], BRANCH};
      default: return {im, a, 3'b000, d, JALR};
    endcase
  endfunction

  initial begin
    logic [31:0] pc;
    dif.Instraction_pype = NOP;
    dif.PC_pype0 = 32'h0;
    dif.PCp4_pype0 = 32'h4;
    dif.flush = 1'b0;
    dif.wb_we = 1'b0;
    dif.wb_rd = 5'd0;
    dif.wb_data = 32'h0;
    m_rf[0] = 32'h0;

    drive(NOP, 32'h0, 0, 0, 0, 0, 1);
    drive(NOP, 32'h0, 0, 0, 0, 0, 1);
    #3;
    chk("reset valid_pype1", dif.valid_pype1, 32'd0);
    chk("reset PC_pype1", dif.PC_pype1, 32'h0001_0000);
    chk("reset PCp4_pype1", dif.PCp4_pype1, 32'h0001_0004);
    chk("reset keep", dif.keep, 32'd0);
    chk("reset early_ctrl", dif.branch_PC_early_contral, 32'd0);

    for (int i = 1; i < 32; i++) drive(NOP, 32'h0, 0, 1, 5'(i), $urandom);

    // register read after writeback, then same-cycle bypass
    drive(NOP, 32'h0, 0, 1, 5'd5, 32'h1234);
    drive(ADDI6, 32'h0001_0000);
    drive(NOP, 32'h0001_0004);
    drive(NOP, 32'h0001_0008);
    #3;
    chk("addi rs1_data", dif.rs1_data_pype1, 32'h1234);
    chk("addi imm", dif.imm_pype1, 32'd1);
    chk("addi rd", dif.rd_pype1, 32'd6);
    chk("addi reg_write", dif.reg_write_pype1, 32'd1);
    drive(ADDI10, 32'h0001_0004);
    drive(NOP, 32'h0001_0008, 0, 1, 5'd9, 32'hBEEF);
    drive(NOP, 32'h0001_000C);
    #3;
    chk("bypass rs1_data", dif.rs1_data_pype1, 32'hBEEF);
    chk("bypass rd", dif.rd_pype1, 32'd10);

    // load-use stall
    drive(LW7, 32'h0001_0100);
    drive(ADD8, 32'h0001_0104);
    drive(NOP, 32'h0001_0108);
    #3 chk("loaduse keep", dif.keep, 32'd1);
    drive(NOP, 32'h0001_0108);
    #3;
    chk("loaduse keep released", dif.keep, 32'd0);
    chk("loaduse bubble", dif.valid_pype1, 32'd0);
    drive(NOP, 32'h0001_010C);
    #3;
    chk("loaduse add valid", dif.valid_pype1, 32'd1);
    chk("loaduse add rs1", dif.rs1_pype1, 32'd7);
    chk("loaduse add rd", dif.rd_pype1, 32'd8);

    // JAL early redirect
    drive(JAL20, 32'h0001_0010);
    drive(ADDI11, 32'h0001_0014);
    #3;
`ifdef DECODE_EARLY_BRANCH_EN
    chk("jal early_ctrl", dif.branch_PC_early_contral, 32'd1);
    chk("jal early_pc", dif.branch_PC_early, 32'h0001_0030);
`else
    chk("jal early_ctrl off", dif.branch_PC_early_contral, 32'd0);
    chk("jal early_pc off", dif.branch_PC_early, 32'd0);
`endif
    drive(NOP, 32'h0001_0018);
    #3;
    chk("jal early_ctrl one cycle", dif.branch_PC_early_contral, 32'd0);
    chk("jal rd", dif.rd_pype1, 32'd1);
    drive(NOP, 32'h0001_001C);
    #3;
`ifdef DECODE_EARLY_BRANCH_EN
    chk("jal wrong path killed", dif.valid_pype1, 32'd0);
`else
    chk("jal wrong path kept", dif.rd_pype1, 32'd11);
`endif

    // BEQ: independent then dependent
    drive(NOP, 32'h0, 0, 1, 5'd3, 32'h55);
    drive(NOP, 32'h0, 0, 1, 5'd4, 32'h55);
    drive(BEQ34, 32'h0001_0040);
    drive(NOP, 32'h0001_0044);
    #3;
`ifdef DECODE_EARLY_BRANCH_EN
    chk("beq early_ctrl", dif.branch_PC_early_contral, 32'd1);
    chk("beq early_pc", dif.branch_PC_early, 32'h0001_0050);
`else
    chk("beq early_ctrl off", dif.branch_PC_early_contral, 32'd0);
`endif
    drive(ADDI3, 32'h0001_0060);
    drive(BEQ34, 32'h0001_0064);
    drive(NOP, 32'h0001_0068);
    #3 chk("dep beq early_ctrl", dif.branch_PC_early_contral, 32'd0);
    drive(NOP, 32'h0001_006C);
    #3;
    chk("dep beq valid", dif.valid_pype1, 32'd1);
    chk("dep beq opcode", dif.opcode_pype1, 32'h63);
    chk("dep beq early_taken", dif.early_taken_pype1, 32'd0);

    // flush during a load-use stall
    drive(LW7, 32'h0001_0100);
    drive(ADD8, 32'h0001_0104);
    drive(NOP, 32'h0001_0108, 1);
    #3;
    chk("flush keep", dif.keep, 32'd0);
    chk("flush early_ctrl", dif.branch_PC_early_contral, 32'd0);
    drive(NOP, 32'h0001_010C);
    #3 chk("flush idex bubble", dif.valid_pype1, 32'd0);
    drive(NOP, 32'h0001_0110);
    #3 chk("flush ifid cleared", dif.valid_pype1, 32'd0);

    // reset in the middle of a stall
    drive(LW7, 32'h0001_0100);
    drive(ADD8, 32'h0001_0104);
    drive(NOP, 32'h0001_0108, 0, 0, 0, 0, 1);
    drive(NOP, 32'h0001_0108);
    #3;
    chk("reset stall keep", dif.keep, 32'd0);
    chk("reset stall PC_pype1", dif.PC_pype1, 32'h0001_0000);

    pc = 32'h0002_0000;
    for (int i = 0; i < 3000; i++) begin
      drive(rand_instr(), pc, ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 199) == 0));
      pc = pc + 32'd4;
    end
    drive(NOP, pc);
    drive(NOP, pc);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
